quire_accum_gen: RTL and testbench

//  Parametrised quire accumulator, successor to the fixed posit<4,0> quire.

---
 rtl/quire_accum_gen_pkg.sv | 24 ++
 rtl/quire_accum_gen_if.sv | 43 ++++
 rtl/quire_accum_gen_align.sv | 30 +++
 rtl/quire_accum_gen.sv | 145 ++++++++++++++
 tb/tb_quire_accum_gen.sv | 250 +++++++++++++++++++++++++
 5 files changed

// File: rtl/quire_accum_gen_pkg.sv
// rtl/quire_accum_gen_pkg.sv - posit/quire geometry helpers and shared types
package quire_accum_gen_pkg;

    typedef struct packed {
        logic nar;
        logic ovf;
    } quire_flags_t;

    function automatic int nqmin(input int n, input int es);
        return (2 ** (es + 2)) * (n - 2) + 1;
    endfunction

    function automatic int frac_w(input int n, input int es, input int prod);
        return (prod != 0) ? 2 * (n - es - 3) : (n - es - 3);
    endfunction

    // Signed scale width: one magnitude bit count plus a sign bit
    function automatic int scale_w(input int n, input int es, input int prod);
        int max_scale;
        max_scale = (n - 2) * (2 ** es) * ((prod != 0) ? 2 : 1);
        return $clog2(max_scale + 1) + 1;
    endfunction

endpackage

// File: rtl/quire_accum_gen_if.sv
// rtl/quire_accum_gen_if.sv - element input and quire output stream bundle
interface quire_accum_gen_if #(
    parameter int POSIT_WIDTH   = 8,
    parameter int ES            = 0,
    parameter int LOG_NB_ACCUM  = 10,
    parameter int IS_PROD_ACCUM = 0
);
    import quire_accum_gen_pkg::*;

    localparam int FRAC_W  = frac_w(POSIT_WIDTH, ES, IS_PROD_ACCUM);
    localparam int SCALE_W = scale_w(POSIT_WIDTH, ES, IS_PROD_ACCUM);
    localparam int NQ      = nqmin(POSIT_WIDTH, ES) + LOG_NB_ACCUM;

    logic                      rts_i;
    logic                      rtr_o;
    logic                      sow_i;
    logic                      eow_i;
    logic [FRAC_W-1:0]         fraction;
    logic signed [SCALE_W-1:0] scale;
    logic                      sign_i;
    logic                      zero_i;
    logic                      NaR_i;
    logic                      rtr_i;
    logic                      rts_o;
    logic                      sow_o;
    logic                      eow_o;
    logic [NQ-1:0]             data_o;
    logic                      NaR_o;
    logic                      ovf_o;
    logic                      sign_o;
    logic                      zero_o;

    modport slave (
        input  rts_i, sow_i, eow_i, fraction, scale, sign_i, zero_i, NaR_i, rtr_i,
        output rtr_o, rts_o, sow_o, eow_o, data_o, NaR_o, ovf_o, sign_o, zero_o
    );

    modport master (
        output rts_i, sow_i, eow_i, fraction, scale, sign_i, zero_i, NaR_i, rtr_i,
        input  rtr_o, rts_o, sow_o, eow_o, data_o, NaR_o, ovf_o, sign_o, zero_o
    );

endinterface

// File: rtl/quire_accum_gen_align.sv
// rtl/quire_accum_gen_align.sv - signed-scale barrel shifter placing a significand in the quire
module quire_align #(
    parameter int FRAC_W  = 5,
    parameter int SCALE_W = 4,
    parameter int NQ      = 35,
    parameter int BPP     = 12
) (
    input  logic [FRAC_W-1:0]         fraction,
    input  logic signed [SCALE_W-1:0] scale,
    input  logic                      zero,
    output logic [NQ-1:0]             mag
);
    localparam int OFF = BPP - FRAC_W;

    logic [NQ-1:0] mant;
    int            sh;

    // Significand LSB lands at bit OFF+scale; bits shifted below bit 0 are dropped
    always_comb begin
        mant             = '0;
        mant[FRAC_W:0]   = zero ? '0 : {1'b1, fraction};
        sh               = OFF + int'(scale);
        if (sh >= 0) begin
            mag = mant << sh;
        end else begin
            mag = mant >> (-sh);
        end
    end

endmodule

// File: rtl/quire_accum_gen.sv
// rtl/quire_accum_gen.sv - windowed exact quire accumulator with sticky NaR and saturation
module quire_accum_gen
    import quire_accum_gen_pkg::*;
#(
    parameter int POSIT_WIDTH   = 8,
    parameter int ES            = 0,
    parameter int LOG_NB_ACCUM  = 10,
    parameter int IS_PROD_ACCUM = 0,
    parameter int EMIT_ALL      = 0
) (
    input logic          clk,
    input logic          rst,
    quire_accum_gen_if.slave bus
);
    localparam int NQMIN   = nqmin(POSIT_WIDTH, ES);
    localparam int NQ      = NQMIN + LOG_NB_ACCUM;
    localparam int BPP     = (NQMIN - 1) / 2;
    localparam int FRAC_W  = frac_w(POSIT_WIDTH, ES, IS_PROD_ACCUM);
    localparam int SCALE_W = scale_w(POSIT_WIDTH, ES, IS_PROD_ACCUM);
    localparam int EW      = FRAC_W + SCALE_W + 5;
    localparam logic [NQ-1:0] Q_MAX = {1'b0, {(NQ-1){1'b1}}};
    localparam logic [NQ-1:0] Q_MIN = {1'b1, {(NQ-1){1'b0}}};
    localparam logic EMIT_EVERY = (EMIT_ALL != 0);

    logic process_en, receive_en;
    logic rtr_q, rtr_d;
    logic skid_vld_q, skid_vld_d;
    logic [EW-1:0] skid_q, skid_d, in_elem, src_elem;
    logic src_vld, src_sow, src_eow, src_sign, src_zero, src_nar;
    logic [FRAC_W-1:0] src_frac;
    logic signed [SCALE_W-1:0] src_scale;
    logic [NQ-1:0] aligned;

    logic s1_vld_q, s1_vld_d, s1_sow_q, s1_sow_d, s1_eow_q, s1_eow_d;
    logic s1_sign_q, s1_sign_d, s1_nar_q, s1_nar_d;
    logic [NQ-1:0] s1_mag_q, s1_mag_d;
    logic s2_vld_q, s2_vld_d, s2_sow_q, s2_sow_d, s2_eow_q, s2_eow_d, s2_nar_q, s2_nar_d;
    logic [NQ:0] s2_op_q, s2_op_d;
    logic rts_q, rts_d, sow_o_q, sow_o_d, eow_o_q, eow_o_d;
    logic [NQ-1:0] q_q, q_d, base;
    logic [NQ:0] sum;
    quire_flags_t flags_q, flags_d, flags_in;

    assign process_en = bus.rtr_i | ~rts_q;
    assign receive_en = bus.rts_i & rtr_q;
    assign in_elem    = {bus.sow_i, bus.eow_i, bus.sign_i, bus.zero_i, bus.NaR_i, bus.fraction, bus.scale};
    assign src_elem   = skid_vld_q ? skid_q : in_elem;
    assign src_vld    = skid_vld_q | receive_en;
    assign {src_sow, src_eow, src_sign, src_zero, src_nar, src_frac, src_scale} = src_elem;

    quire_align #(.FRAC_W(FRAC_W), .SCALE_W(SCALE_W), .NQ(NQ), .BPP(BPP)) u_align (
        .fraction (src_frac),
        .scale    (src_scale),
        .zero     (src_zero),
        .mag      (aligned)
    );

    // Upstream ready and one-entry skid that absorbs the element accepted while stalling
    always_comb begin
        rtr_d      = process_en;
        skid_vld_d = skid_vld_q;
        skid_d     = skid_q;
        if (receive_en && !process_en) begin
            skid_vld_d = 1'b1;
            skid_d     = in_elem;
        end else if (process_en) begin
            skid_vld_d = 1'b0;
        end
    end

    // S1 aligns the significand, S2 applies the sign as a two's-complement operand
    always_comb begin
        s1_vld_d = s1_vld_q; s1_sow_d = s1_sow_q; s1_eow_d = s1_eow_q;
        s1_sign_d = s1_sign_q; s1_nar_d = s1_nar_q; s1_mag_d = s1_mag_q;
        s2_vld_d = s2_vld_q; s2_sow_d = s2_sow_q; s2_eow_d = s2_eow_q;
        s2_nar_d = s2_nar_q; s2_op_d = s2_op_q;
        if (process_en) begin
            s1_vld_d = src_vld; s1_sow_d = src_sow; s1_eow_d = src_eow;
            s1_sign_d = src_sign; s1_nar_d = src_nar; s1_mag_d = aligned;
            s2_vld_d = s1_vld_q; s2_sow_d = s1_sow_q; s2_eow_d = s1_eow_q;
            s2_nar_d = s1_nar_q;
            s2_op_d  = s1_sign_q ? (~{1'b0, s1_mag_q} + 1'b1) : {1'b0, s1_mag_q};
        end
    end

    // S3 accumulates; sow restarts from zero, NaR or saturation freeze the quire until sow
    always_comb begin
        base     = s2_sow_q ? '0 : q_q;
        flags_in = s2_sow_q ? '0 : flags_q;
        sum      = {base[NQ-1], base} + s2_op_q;
        q_d = q_q; flags_d = flags_q;
        rts_d = rts_q; sow_o_d = sow_o_q; eow_o_d = eow_o_q;
        if (process_en) begin
            rts_d = s2_vld_q & (EMIT_EVERY | s2_eow_q);
            if (s2_vld_q) begin
                sow_o_d = s2_sow_q;
                eow_o_d = s2_eow_q;
                q_d     = base;
                flags_d = flags_in;
                if (s2_nar_q) begin
                    flags_d.nar = 1'b1;
                end else if (!flags_in.nar && !flags_in.ovf) begin
                    if (sum[NQ] != sum[NQ-1]) begin
                        q_d         = sum[NQ] ? Q_MIN : Q_MAX;
                        flags_d.ovf = 1'b1;
                    end else begin
                        q_d = sum[NQ-1:0];
                    end
                end
            end
        end
    end

    // State registers
    always_ff @(posedge clk) begin
        if (rst) begin
            rtr_q <= 1'b0; skid_vld_q <= 1'b0; skid_q <= '0;
            s1_vld_q <= 1'b0; s1_sow_q <= 1'b0; s1_eow_q <= 1'b0;
            s1_sign_q <= 1'b0; s1_nar_q <= 1'b0; s1_mag_q <= '0;
            s2_vld_q <= 1'b0; s2_sow_q <= 1'b0; s2_eow_q <= 1'b0;
            s2_nar_q <= 1'b0; s2_op_q <= '0;
            rts_q <= 1'b0; sow_o_q <= 1'b0; eow_o_q <= 1'b0;
            q_q <= '0; flags_q <= '0;
        end else begin
            rtr_q <= rtr_d; skid_vld_q <= skid_vld_d; skid_q <= skid_d;
            s1_vld_q <= s1_vld_d; s1_sow_q <= s1_sow_d; s1_eow_q <= s1_eow_d;
            s1_sign_q <= s1_sign_d; s1_nar_q <= s1_nar_d; s1_mag_q <= s1_mag_d;
            s2_vld_q <= s2_vld_d; s2_sow_q <= s2_sow_d; s2_eow_q <= s2_eow_d;
            s2_nar_q <= s2_nar_d; s2_op_q <= s2_op_d;
            rts_q <= rts_d; sow_o_q <= sow_o_d; eow_o_q <= eow_o_d;
            q_q <= q_d; flags_q <= flags_d;
        end
    end

    assign bus.rtr_o  = rtr_q;
    assign bus.rts_o  = rts_q;
    assign bus.sow_o  = sow_o_q;
    assign bus.eow_o  = eow_o_q;
    assign bus.data_o = q_q;
    assign bus.NaR_o  = flags_q.nar;
    assign bus.ovf_o  = flags_q.ovf;
    assign bus.sign_o = q_q[NQ-1];
    assign bus.zero_o = (q_q == '0);

endmodule

// File: tb/tb_quire_accum_gen.sv
// tb/tb_quire_accum_gen.sv - directed vector bench for quire_accum_gen
module tb_quire_accum_gen;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic rts_i, sow_i, eow_i, sign_i, zero_i, nar_i, rtr_i;
    logic [4:0] frac;
    logic signed [3:0] scale_s;

    quire_accum_gen_if #(.POSIT_WIDTH(8), .ES(0), .LOG_NB_ACCUM(10), .IS_PROD_ACCUM(0)) if0 (), if1 ();
    quire_accum_gen_if #(.POSIT_WIDTH(8), .ES(0), .LOG_NB_ACCUM(0), .IS_PROD_ACCUM(0)) if2 ();

    assign {if0.rts_i, if0.sow_i, if0.eow_i, if0.sign_i, if0.zero_i, if0.NaR_i, if0.rtr_i} = {rts_i, sow_i, eow_i, sign_i, zero_i, nar_i, rtr_i};
    assign {if1.rts_i, if1.sow_i, if1.eow_i, if1.sign_i, if1.zero_i, if1.NaR_i, if1.rtr_i} = {rts_i, sow_i, eow_i, sign_i, zero_i, nar_i, rtr_i};
    assign {if2.rts_i, if2.sow_i, if2.eow_i, if2.sign_i, if2.zero_i, if2.NaR_i, if2.rtr_i} = {rts_i, sow_i, eow_i, sign_i, zero_i, nar_i, rtr_i};
    assign if0.fraction = frac; assign if0.scale = scale_s;
    assign if1.fraction = frac; assign if1.scale = scale_s;
    assign if2.fraction = frac; assign if2.scale = scale_s;

    quire_accum_gen #(.POSIT_WIDTH(8), .ES(0), .LOG_NB_ACCUM(10), .IS_PROD_ACCUM(0), .EMIT_ALL(0)) u0 (.clk(clk), .rst(rst), .bus(if0));
    quire_accum_gen #(.POSIT_WIDTH(8), .ES(0), .LOG_NB_ACCUM(10), .IS_PROD_ACCUM(0), .EMIT_ALL(1)) u1 (.clk(clk), .rst(rst), .bus(if1));
    quire_accum_gen #(.POSIT_WIDTH(8), .ES(0), .LOG_NB_ACCUM(0), .IS_PROD_ACCUM(0), .EMIT_ALL(0)) u2 (.clk(clk), .rst(rst), .bus(if2));

    typedef struct {
        logic [63:0] data;
        logic nar, ovf, sow, eow, sgn, zro;
    } out_t;

    typedef struct {
        logic sow, eow, sign, zero, nar;
        logic [4:0] frac;
        int scale;
        longint exp_q;
        logic exp_nar;
    } vec_t;

    out_t q0[$], q1[$], q2[$];
    longint exp5[$];
    vec_t tbl[13];
    int checks = 0;
    int failures = 0;
    logic stall0 = 1'b0;
    logic [63:0] prev0 = '0;
    logic done5;

    function automatic void chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", name, got, exp);
        end
    endfunction

    function automatic logic [63:0] msk(input longint v, input int w);
        logic [63:0] u;
        u = v;
        return u & ((64'd1 << w) - 64'd1);
    endfunction

    // Capture every accepted output beat; while u0 stalls, its output must not move
    always @(negedge clk) begin
        if (rst) begin
            stall0 = 1'b0;
        end else begin
            if (stall0) begin
                chk("hold_rts", 64'(if0.rts_o), 64'd1);
                chk("hold_data", 64'(if0.data_o), prev0);
            end
            stall0 = if0.rts_o && !if0.rtr_i;
            prev0  = 64'(if0.data_o);
            if (if0.rts_o && if0.rtr_i) q0.push_back('{64'(if0.data_o), if0.NaR_o, if0.ovf_o, if0.sow_o, if0.eow_o, if0.sign_o, if0.zero_o});
            if (if1.rts_o && if1.rtr_i) q1.push_back('{64'(if1.data_o), if1.NaR_o, if1.ovf_o, if1.sow_o, if1.eow_o, if1.sign_o, if1.zero_o});
            if (if2.rts_o && if2.rtr_i) q2.push_back('{64'(if2.data_o), if2.NaR_o, if2.ovf_o, if2.sow_o, if2.eow_o, if2.sign_o, if2.zero_o});
        end
    end

    task automatic send(input logic s, input logic e, input logic sg, input logic z, input logic n,
                        input logic [4:0] f, input int sc);
        logic acc;
        int guard;
        sow_i = s; eow_i = e; sign_i = sg; zero_i = z; nar_i = n;
        frac = f; scale_s = 4'(sc); rts_i = 1'b1;
        guard = 0;
        forever begin
            @(negedge clk);
            acc = if0.rtr_o;
            @(posedge clk);
            #1;
            if (acc) break;
            guard++;
            if (guard > 50) begin
                chk("send_timeout", 64'd0, 64'd1);
                break;
            end
        end
        rts_i = 1'b0;
    endtask

    task automatic drain();
        repeat (10) @(posedge clk);
        #1;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        int j;
        rst = 1'b1; rts_i = 1'b0; rtr_i = 1'b1;
        sow_i = 1'b0; eow_i = 1'b0; sign_i = 1'b0; zero_i = 1'b0; nar_i = 1'b0;
        frac = '0; scale_s = '0; done5 = 1'b0;

        tbl[0]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0,  0, 64'h1000, 1'b0};
        tbl[1]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd16, 0, 64'h2800, 1'b0};
        tbl[2]  = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 5'd0, -1, 64'h2000, 1'b0};
        tbl[3]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0,  0, 64'h1000, 1'b0};
        tbl[4]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 5'd0,  0, 64'h1000, 1'b1};
        tbl[5]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0,  0, 64'h1000, 1'b1};
        tbl[6]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0,  0, 64'h1000, 1'b0};
        tbl[7]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 5'd16, 0, 64'h2800, 1'b0};
        tbl[8]  = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 5'd0,  0, -64'sd4096, 1'b0};
        tbl[9]  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 5'd0,  0, 64'h0, 1'b0};
        tbl[10] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 5'd8,  0, 64'h1400, 1'b0};
        tbl[11] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, -1, 64'h1C00, 1'b0};
        tbl[12] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 5'd31, -6, 64'h7E, 1'b0};

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_rtr_o", 64'(if0.rtr_o), 64'd0);
        chk("rst_rts_o", 64'(if0.rts_o), 64'd0);
        chk("rst_data_o", 64'(if0.data_o), 64'd0);
        chk("rst_flags", {62'd0, if0.NaR_o, if0.ovf_o}, 64'd0);
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        chk("rtr_o_after_rst0", 64'(if0.rtr_o), 64'd0);
        @(negedge clk);
        chk("rtr_o_after_rst1", 64'(if0.rtr_o), 64'd1);
        @(posedge clk); #1;

        // Windows from the vector table, back to back
        for (int i = 0; i < 13; i++)
            send(tbl[i].sow, tbl[i].eow, tbl[i].sign, tbl[i].zero, tbl[i].nar, tbl[i].frac, tbl[i].scale);
        drain();
        chk("emit_all_count", 64'(q1.size()), 64'd13);
        for (int i = 0; i < 13 && i < q1.size(); i++) begin
            chk($sformatf("all_data[%0d]", i), q1[i].data, msk(tbl[i].exp_q, 35));
            chk($sformatf("all_nar[%0d]", i), 64'(q1[i].nar), 64'(tbl[i].exp_nar));
            chk($sformatf("all_sow_eow[%0d]", i), {62'd0, q1[i].sow, q1[i].eow}, {62'd0, tbl[i].sow, tbl[i].eow});
            chk($sformatf("all_sgn_zro[%0d]", i), {62'd0, q1[i].sgn, q1[i].zro},
                {62'd0, tbl[i].exp_q < 0, tbl[i].exp_q == 0});
        end
        chk("eow_count", 64'(q0.size()), 64'd7);
        chk("eow_count_nq25", 64'(q2.size()), 64'd7);
        j = 0;
        for (int i = 0; i < 13; i++) begin
            if (tbl[i].eow && j < q0.size() && j < q2.size()) begin
                chk($sformatf("win_data[%0d]", i), q0[j].data, msk(tbl[i].exp_q, 35));
                chk($sformatf("win_nar[%0d]", i), 64'(q0[j].nar), 64'(tbl[i].exp_nar));
                chk($sformatf("win_eow[%0d]", i), 64'(q0[j].eow), 64'd1);
                chk($sformatf("win25_data[%0d]", i), q2[j].data, msk(tbl[i].exp_q, 25));
                j++;
            end
        end
        q0.delete(); q1.delete(); q2.delete();

        // Saturation with no guard bits, then a clean window
        for (int i = 0; i < 64; i++) send(i == 0, i == 63, 1'b0, 1'b0, 1'b0, 5'd0, 6);
        send(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 0);
        drain();
        chk("sat_count", 64'(q2.size()), 64'd2);
        if (q2.size() >= 2) begin
            chk("sat_data", q2[0].data, 64'h0FFFFFF);
            chk("sat_ovf", 64'(q2[0].ovf), 64'd1);
            chk("post_sat_data", q2[1].data, 64'h1000);
            chk("post_sat_ovf", 64'(q2[1].ovf), 64'd0);
        end
        chk("wide_count", 64'(q0.size()), 64'd2);
        if (q0.size() >= 1) begin
            chk("wide_data", q0[0].data, 64'h1000000);
            chk("wide_ovf", 64'(q0[0].ovf), 64'd0);
        end
        q0.delete(); q1.delete(); q2.delete();

        // 20 windows with downstream ready toggling every cycle
        fork
            begin
                int n;
                n = 0;
                while (!done5 && n < 3000) begin
                    @(posedge clk); #1;
                    rtr_i = ~rtr_i;
                    n++;
                end
            end
            begin
                longint acc_v, v;
                int len, f, s, sg;
                for (int w = 0; w < 20; w++) begin
                    acc_v = 0;
                    len = 1 + (w % 3);
                    for (int k = 0; k < len; k++) begin
                        f  = (w * 7 + k * 3) % 32;
                        s  = ((w + k) % 7) - 3;
                        sg = (w + k) % 2;
                        v  = longint'(32 + f) * (longint'(1) << (7 + s));
                        acc_v = (sg != 0) ? acc_v - v : acc_v + v;
                        send(k == 0, k == len - 1, sg[0], 1'b0, 1'b0, f[4:0], s);
                    end
                    exp5.push_back(acc_v);
                end
                done5 = 1'b1;
            end
        join
        rtr_i = 1'b1;
        drain();
        chk("stall_count", 64'(q0.size()), 64'd20);
        for (int i = 0; i < 20 && i < q0.size(); i++)
            chk($sformatf("stall_win[%0d]", i), q0[i].data, msk(exp5[i], 35));

        // Mid-window reset, then a fresh window
        send(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 0);
        send(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd16, 0);
        rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        chk("mid_rst_rts", {62'd0, if0.rts_o, if1.rts_o}, 64'd0);
        chk("mid_rst_data0", 64'(if0.data_o), 64'd0);
        chk("mid_rst_data1", 64'(if1.data_o), 64'd0);
        chk("mid_rst_misc", {59'd0, if1.sow_o, if1.eow_o, if1.NaR_o, if1.ovf_o, if1.rtr_o}, 64'd0);
        q0.delete(); q1.delete(); q2.delete();
        @(posedge clk); #1;
        send(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 0);
        send(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 5'd16, 0);
        drain();
        chk("after_rst_count", 64'(q0.size()), 64'd1);
        if (q0.size() >= 1) chk("after_rst_data", q0[0].data, 64'h2800);
        chk("after_rst_all_count", 64'(q1.size()), 64'd2);
        if (q1.size() >= 2) chk("after_rst_all_first", q1[0].data, 64'h1000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
